apb_slave_sel_ctrl: RTL and testbench

// - Sits between the AHB-to-APB bridge master side (psel_en/penable/paddr/pwrite) and NUM_SLAVES APB slaves.
// - Decodes paddr to a one-hot psel_x and muxes pready/pslverr/prdata back to the bridge.
// - Runs a per-transfer watchdog: a slave that stalls is aborted with an error response, so the bridge never hangs.
// - Decode misses also return an error response; a sticky status bit records any abort.

---
 rtl/apb_slave_sel_ctrl_pkg.sv | 23 ++
 rtl/apb_wdt_counter.sv | 35 +++
 rtl/apb_slave_sel_ctrl.sv | 147 ++++++++++++++
 tb/tb_apb_slave_sel_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_sel_ctrl_pkg.sv
// Shared bus widths and FSM encodings for the APB slave select controller.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_slave_sel_ctrl_pkg;

  // Bus widths shared with the AHB-to-APB bridge.
  localparam int PADDR_W = `PADDR_WIDTH;
  localparam int APB_DW  = `APB_DATA_WIDTH;

  // Controller states: IDLE carries normal traffic, ABORT issues one forced
  // error beat, HOLD waits for the bridge to drop psel_en after an abort.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ABORT = 2'b01,
    ST_HOLD  = 2'b10
  } sel_state_e;

endpackage

// File: rtl/apb_wdt_counter.sv
// Per-transfer watchdog: counts stalled access-phase cycles and flags the
// cycle in which the limit is reached while the slave is still not ready.
module apb_wdt_counter #(
  parameter int CNT_W       = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic hclk,
  input  logic hreset,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);
  localparam bit               WDT_ON   = (TIMEOUT_CYC != 0);

  logic [CNT_W-1:0] cnt_reg;
  logic             at_term;

  assign at_term = (cnt_reg == TERM_CNT);
  // A zero limit disables the watchdog entirely; the counter then never moves.
  assign expire  = WDT_ON & at_term & inc;

  // Stall counter: restarts on every completed/abandoned transfer and on expiry.
  always_ff @(posedge hclk) begin
    if (hreset || !WDT_ON) begin
      cnt_reg <= '0;
    end else if (clr || expire) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_slave_sel_ctrl.sv
// APB slave select controller: address decode to one-hot psel, response mux
// back to the bridge, watchdog abort of stalled slaves and a sticky abort flag.
module apb_slave_sel_ctrl
  import apb_slave_sel_ctrl_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_LSB     = 12,
  parameter int SEL_BITS    = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic                         psel_en,
  input  logic                         penable,
  input  logic [PADDR_W-1:0]           paddr,
  output logic                         pready_x,
  output logic                         pslverr_x,
  output logic [APB_DW-1:0]            prdata_x,
  output logic [NUM_SLAVES-1:0]        psel,
  input  logic [NUM_SLAVES-1:0]        pready_s,
  input  logic [NUM_SLAVES-1:0]        pslverr_s,
  input  logic [NUM_SLAVES*APB_DW-1:0] prdata_s,
  output logic                         abort_sticky,
  input  logic                         abort_clr
);

  sel_state_e state_reg;
  logic       rst_gate_reg;
  logic       abort_sticky_reg;

  logic [SEL_BITS-1:0]   idx;
  logic                  hit;
  logic [NUM_SLAVES-1:0] slot_match;
  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [APB_DW-1:0]     prdata_sel;

  logic live;
  logic in_idle;
  logic in_abort;
  logic access;
  logic miss_resp;
  logic wdt_inc;
  logic wdt_clr;
  logic wdt_expire;
  logic abort_set;
  logic unused_paddr;

  // Only the slot-index field of paddr matters here; the rest belongs to the slave.
  assign unused_paddr = ^paddr;

  assign idx = paddr[SEL_LSB +: SEL_BITS];
  assign hit = ({1'b0, idx} < (SEL_BITS + 1)'(NUM_SLAVES));

  // One decode line per populated slot.
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
      assign slot_match[gi] = hit & (idx == SEL_BITS'(gi));
    end
  endgenerate

  assign pready_sel  = |(pready_s & slot_match);
  assign pslverr_sel = |(pslverr_s & slot_match);

  // Read-data mux as an AND-OR tree over the one-hot decode.
  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slot_match[i]) begin
        prdata_sel = prdata_sel | prdata_s[i*APB_DW +: APB_DW];
      end
    end
  end

  // Outputs stay quiet from the reset edge until the first edge after release,
  // so a transfer cut by reset never sees a select or a response.
  assign live      = ~rst_gate_reg;
  assign in_idle   = live & (state_reg == ST_IDLE);
  assign in_abort  = live & (state_reg == ST_ABORT);
  assign access    = in_idle & psel_en & penable;
  assign miss_resp = access & ~hit;

  assign psel = {NUM_SLAVES{in_idle & psel_en}} & slot_match;

  // Response to the bridge: forced error during ABORT or on a decode miss,
  // otherwise the selected slave's response during the access phase.
  always_comb begin
    pready_x  = 1'b0;
    pslverr_x = 1'b0;
    prdata_x  = '0;
    if (in_abort) begin
      pready_x  = 1'b1;
      pslverr_x = 1'b1;
    end else if (access) begin
      if (hit) begin
        pready_x  = pready_sel;
        pslverr_x = pslverr_sel;
        prdata_x  = prdata_sel;
      end else begin
        pready_x  = 1'b1;
        pslverr_x = 1'b1;
      end
    end
  end

  // A ready slave in the terminal cycle suppresses inc, so it wins over expiry.
  assign wdt_inc = access & hit & ~pready_sel;
  assign wdt_clr = ~psel_en | pready_x;

  apb_wdt_counter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdt (
    .hclk   (hclk),
    .hreset (hreset),
    .inc    (wdt_inc),
    .clr    (wdt_clr),
    .expire (wdt_expire)
  );

  assign abort_set    = in_abort | miss_resp;
  assign abort_sticky = abort_sticky_reg;

  // Controller FSM, reset output gate and sticky abort flag (set beats clear).
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_reg        <= ST_IDLE;
      rst_gate_reg     <= 1'b1;
      abort_sticky_reg <= 1'b0;
    end else begin
      rst_gate_reg <= 1'b0;
      case (state_reg)
        ST_IDLE:  if (wdt_expire) state_reg <= ST_ABORT;
        ST_ABORT: state_reg <= ST_HOLD;
        ST_HOLD:  if (!psel_en) state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
      if (abort_set) begin
        abort_sticky_reg <= 1'b1;
      end else if (abort_clr) begin
        abort_sticky_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_sel_ctrl.sv
// Directed bench for apb_slave_sel_ctrl: a 4-slot instance for decode, mux
// and watchdog scenarios and a 3-slot instance for the decode-miss path.
module tb_apb_slave_sel_ctrl;
  import apb_slave_sel_ctrl_pkg::*;

  logic         hclk = 1'b0;
  logic         hreset;
  logic         psel_en;
  logic         penable;
  logic         abort_clr;
  logic [31:0]  paddr;
  logic [3:0]   pready_s;
  logic [3:0]   pslverr_s;
  logic [127:0] prdata_s;

  logic         pready_x4, pslverr_x4, sticky4;
  logic [31:0]  prdata_x4;
  logic [3:0]   psel4;
  logic         pready_x3, pslverr_x3, sticky3;
  logic [31:0]  prdata_x3;
  logic [2:0]   psel3;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  apb_slave_sel_ctrl #(
    .NUM_SLAVES(4), .SEL_LSB(12), .SEL_BITS(2), .TIMEOUT_CYC(16), .CNT_W(5)
  ) dut4 (
    .hclk(hclk), .hreset(hreset), .psel_en(psel_en), .penable(penable), .paddr(paddr),
    .pready_x(pready_x4), .pslverr_x(pslverr_x4), .prdata_x(prdata_x4), .psel(psel4),
    .pready_s(pready_s), .pslverr_s(pslverr_s), .prdata_s(prdata_s),
    .abort_sticky(sticky4), .abort_clr(abort_clr)
  );

  apb_slave_sel_ctrl #(
    .NUM_SLAVES(3), .SEL_LSB(12), .SEL_BITS(2), .TIMEOUT_CYC(16), .CNT_W(5)
  ) dut3 (
    .hclk(hclk), .hreset(hreset), .psel_en(psel_en), .penable(penable), .paddr(paddr),
    .pready_x(pready_x3), .pslverr_x(pslverr_x3), .prdata_x(prdata_x3), .psel(psel3),
    .pready_s(pready_s[2:0]), .pslverr_s(pslverr_s[2:0]), .prdata_s(prdata_s[95:0]),
    .abort_sticky(sticky3), .abort_clr(abort_clr)
  );

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    @(negedge hclk);
  endtask

  task automatic test_reset();
    hreset = 1'b1; psel_en = 1'b1; penable = 1'b1; abort_clr = 1'b0;
    paddr = 32'h0000_1010; pready_s = 4'hF; pslverr_s = 4'hF; prdata_s = {4{32'hFFFF_FFFF}};
    tick(); tick(); settle();
    checks++; if (psel4 !== 4'b0000) begin errors++; $display("FAIL rst_psel: got %b want 0000", psel4); end
    checks++; if (pready_x4 !== 1'b0) begin errors++; $display("FAIL rst_pready: got %b want 0", pready_x4); end
    checks++; if (pslverr_x4 !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b want 0", pslverr_x4); end
    checks++; if (prdata_x4 !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h want 0", prdata_x4); end
    checks++; if (sticky4 !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b want 0", sticky4); end
    tick();
    hreset = 1'b0; psel_en = 1'b0; penable = 1'b0; pready_s = 4'h0; pslverr_s = 4'h0; prdata_s = '0;
    tick();
    $display("[reset] outputs quiet while reset held");
  endtask

  task automatic test_write_slot1();
    tick(); psel_en = 1'b1; penable = 1'b0; paddr = 32'h0000_1010; pready_s = 4'b0010; settle();
    checks++; if (psel4 !== 4'b0010) begin errors++; $display("FAIL wr_setup_psel: got %b want 0010", psel4); end
    checks++; if (pready_x4 !== 1'b0) begin errors++; $display("FAIL wr_setup_pready: got %b want 0", pready_x4); end
    tick(); penable = 1'b1; settle();
    checks++; if (psel4 !== 4'b0010) begin errors++; $display("FAIL wr_access_psel: got %b want 0010", psel4); end
    checks++; if (pready_x4 !== 1'b1) begin errors++; $display("FAIL wr_access_pready: got %b want 1", pready_x4); end
    checks++; if (pslverr_x4 !== 1'b0) begin errors++; $display("FAIL wr_access_pslverr: got %b want 0", pslverr_x4); end
    tick(); psel_en = 1'b0; penable = 1'b0; pready_s = 4'b0000; settle();
    checks++; if (psel4 !== 4'b0000) begin errors++; $display("FAIL wr_end_psel: got %b want 0000", psel4); end
    $display("[write] slot1 addr=%h zero wait states", 32'h0000_1010);
  endtask

  task automatic test_read_wait();
    prdata_s = {32'hBEEF_0003, 32'hA5A5_0002, 32'hDEAD_0001, 32'h1111_0000};
    pslverr_s = 4'b0010;
    tick(); psel_en = 1'b1; penable = 1'b0; paddr = 32'h0000_2000; pready_s = 4'b0000; settle();
    checks++; if (psel4 !== 4'b0100) begin errors++; $display("FAIL rd_setup_psel: got %b want 0100", psel4); end
    for (int w = 1; w <= 3; w++) begin
      tick(); penable = 1'b1; settle();
      checks++; if (pready_x4 !== 1'b0) begin errors++; $display("FAIL rd_wait%0d_pready: got %b want 0", w, pready_x4); end
    end
    tick(); pready_s = 4'b0100; settle();
    checks++; if (prdata_x4 !== 32'hA5A5_0002) begin errors++; $display("FAIL rd_prdata: got %h want a5a50002", prdata_x4); end
    checks++; if (pready_x4 !== 1'b1) begin errors++; $display("FAIL rd_pready: got %b want 1", pready_x4); end
    checks++; if (pslverr_x4 !== 1'b0) begin errors++; $display("FAIL rd_pslverr: got %b want 0", pslverr_x4); end
    checks++; if (psel4 !== 4'b0100) begin errors++; $display("FAIL rd_access_psel: got %b want 0100", psel4); end
    tick(); psel_en = 1'b0; penable = 1'b0; pready_s = 4'b0000; pslverr_s = 4'b0000; settle();
    checks++; if (sticky4 !== 1'b0) begin errors++; $display("FAIL rd_sticky: got %b want 0", sticky4); end
    $display("[read] slot2 addr=%h 3 wait states data=%h", 32'h0000_2000, prdata_x4);
  endtask

  task automatic test_timeout();
    tick(); psel_en = 1'b1; penable = 1'b0; paddr = 32'h0000_3000; pready_s = 4'b0000; settle();
    checks++; if (psel4 !== 4'b1000) begin errors++; $display("FAIL to_setup_psel: got %b want 1000", psel4); end
    for (int a = 1; a <= 16; a++) begin
      tick(); penable = 1'b1; settle();
      checks++; if (pready_x4 !== 1'b0) begin errors++; $display("FAIL to_access%0d_pready: got %b want 0", a, pready_x4); end
    end
    checks++; if (psel4 !== 4'b1000) begin errors++; $display("FAIL to_access16_psel: got %b want 1000", psel4); end
    tick(); settle();
    checks++; if (pready_x4 !== 1'b1) begin errors++; $display("FAIL to_abort_pready: got %b want 1", pready_x4); end
    checks++; if (pslverr_x4 !== 1'b1) begin errors++; $display("FAIL to_abort_pslverr: got %b want 1", pslverr_x4); end
    checks++; if (prdata_x4 !== 32'h0) begin errors++; $display("FAIL to_abort_prdata: got %h want 0", prdata_x4); end
    checks++; if (psel4 !== 4'b0000) begin errors++; $display("FAIL to_abort_psel: got %b want 0000", psel4); end
    tick(); settle();
    checks++; if (pready_x4 !== 1'b0) begin errors++; $display("FAIL to_hold_pready: got %b want 0", pready_x4); end
    checks++; if (psel4 !== 4'b0000) begin errors++; $display("FAIL to_hold_psel: got %b want 0000", psel4); end
    checks++; if (sticky4 !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", sticky4); end
    tick(); settle();
    checks++; if (psel4 !== 4'b0000) begin errors++; $display("FAIL to_hold2_psel: got %b want 0000", psel4); end
    tick(); psel_en = 1'b0; penable = 1'b0; settle();
    tick(); psel_en = 1'b1; paddr = 32'h0000_1010; pready_s = 4'b0010; settle();
    checks++; if (psel4 !== 4'b0010) begin errors++; $display("FAIL to_idle_psel: got %b want 0010", psel4); end
    tick(); penable = 1'b1; settle();
    checks++; if (pready_x4 !== 1'b1) begin errors++; $display("FAIL to_next_pready: got %b want 1", pready_x4); end
    checks++; if (sticky4 !== 1'b1) begin errors++; $display("FAIL to_sticky_kept: got %b want 1", sticky4); end
    tick(); psel_en = 1'b0; penable = 1'b0; pready_s = 4'b0000; abort_clr = 1'b1;
    tick(); abort_clr = 1'b0; settle();
    checks++; if (sticky4 !== 1'b0) begin errors++; $display("FAIL to_sticky_clr: got %b want 0", sticky4); end
    $display("[timeout] slot3 aborted after 16 stalled access cycles");
  endtask

  task automatic test_race();
    tick(); psel_en = 1'b1; penable = 1'b0; paddr = 32'h0000_0000; pready_s = 4'b0000; settle();
    checks++; if (psel4 !== 4'b0001) begin errors++; $display("FAIL race_setup_psel: got %b want 0001", psel4); end
    for (int a = 1; a <= 15; a++) begin
      tick(); penable = 1'b1;
    end
    settle();
    checks++; if (pready_x4 !== 1'b0) begin errors++; $display("FAIL race_access15_pready: got %b want 0", pready_x4); end
    tick(); pready_s = 4'b0001; settle();
    checks++; if (pready_x4 !== 1'b1) begin errors++; $display("FAIL race_pready: got %b want 1", pready_x4); end
    checks++; if (pslverr_x4 !== 1'b0) begin errors++; $display("FAIL race_pslverr: got %b want 0", pslverr_x4); end
    checks++; if (prdata_x4 !== 32'h1111_0000) begin errors++; $display("FAIL race_prdata: got %h want 11110000", prdata_x4); end
    tick(); psel_en = 1'b0; penable = 1'b0; pready_s = 4'b0000; settle();
    checks++; if (pready_x4 !== 1'b0) begin errors++; $display("FAIL race_after_pready: got %b want 0", pready_x4); end
    checks++; if (pslverr_x4 !== 1'b0) begin errors++; $display("FAIL race_after_pslverr: got %b want 0", pslverr_x4); end
    tick(); psel_en = 1'b1; settle();
    checks++; if (psel4 !== 4'b0001) begin errors++; $display("FAIL race_next_psel: got %b want 0001", psel4); end
    checks++; if (sticky4 !== 1'b0) begin errors++; $display("FAIL race_sticky: got %b want 0", sticky4); end
    tick(); psel_en = 1'b0;
    $display("[race] slot0 ready in terminal cycle, normal response");
  endtask

  task automatic test_decode_miss();
    tick(); settle();
    checks++; if (sticky3 !== 1'b0) begin errors++; $display("FAIL miss_sticky_init: got %b want 0", sticky3); end
    tick(); psel_en = 1'b1; penable = 1'b0; paddr = 32'h0000_3000; settle();
    checks++; if (psel3 !== 3'b000) begin errors++; $display("FAIL miss_setup_psel: got %b want 000", psel3); end
    checks++; if (pready_x3 !== 1'b0) begin errors++; $display("FAIL miss_setup_pready: got %b want 0", pready_x3); end
    tick(); penable = 1'b1; settle();
    checks++; if (pready_x3 !== 1'b1) begin errors++; $display("FAIL miss_pready: got %b want 1", pready_x3); end
    checks++; if (pslverr_x3 !== 1'b1) begin errors++; $display("FAIL miss_pslverr: got %b want 1", pslverr_x3); end
    checks++; if (prdata_x3 !== 32'h0) begin errors++; $display("FAIL miss_prdata: got %h want 0", prdata_x3); end
    checks++; if (psel3 !== 3'b000) begin errors++; $display("FAIL miss_access_psel: got %b want 000", psel3); end
    tick(); psel_en = 1'b0; penable = 1'b0; settle();
    checks++; if (sticky3 !== 1'b1) begin errors++; $display("FAIL miss_sticky_set: got %b want 1", sticky3); end
    tick(); psel_en = 1'b1;
    tick(); penable = 1'b1; abort_clr = 1'b1;
    tick(); psel_en = 1'b0; penable = 1'b0; abort_clr = 1'b0; settle();
    checks++; if (sticky3 !== 1'b1) begin errors++; $display("FAIL miss_set_beats_clr: got %b want 1", sticky3); end
    tick(); abort_clr = 1'b1;
    tick(); abort_clr = 1'b0; settle();
    checks++; if (sticky3 !== 1'b0) begin errors++; $display("FAIL miss_sticky_clr: got %b want 0", sticky3); end
    $display("[miss] 3-slot instance index 3 -> error response");
  endtask

  task automatic test_reset_mid();
    tick(); psel_en = 1'b1; penable = 1'b0; paddr = 32'h0000_1010; pready_s = 4'b0000; settle();
    tick(); penable = 1'b1; settle();
    checks++; if (psel4 !== 4'b0010) begin errors++; $display("FAIL rm_wait_psel: got %b want 0010", psel4); end
    tick(); hreset = 1'b1; settle();
    checks++; if (psel4 !== 4'b0010) begin errors++; $display("FAIL rm_pre_edge_psel: got %b want 0010", psel4); end
    tick(); pready_s = 4'b0010; settle();
    checks++; if (psel4 !== 4'b0000) begin errors++; $display("FAIL rm_post_edge_psel: got %b want 0000", psel4); end
    checks++; if (pready_x4 !== 1'b0) begin errors++; $display("FAIL rm_pready: got %b want 0", pready_x4); end
    checks++; if (prdata_x4 !== 32'h0) begin errors++; $display("FAIL rm_prdata: got %h want 0", prdata_x4); end
    tick(); settle();
    checks++; if (psel4 !== 4'b0000) begin errors++; $display("FAIL rm_held_psel: got %b want 0000", psel4); end
    checks++; if (pslverr_x4 !== 1'b0) begin errors++; $display("FAIL rm_held_pslverr: got %b want 0", pslverr_x4); end
    tick(); hreset = 1'b0; psel_en = 1'b0; penable = 1'b0; pready_s = 4'b0000;
    tick(); psel_en = 1'b1; settle();
    checks++; if (psel4 !== 4'b0010) begin errors++; $display("FAIL rm_resume_psel: got %b want 0010", psel4); end
    checks++; if (sticky4 !== 1'b0) begin errors++; $display("FAIL rm_sticky: got %b want 0", sticky4); end
    tick(); psel_en = 1'b0;
    $display("[reset_mid] slot1 transfer cut by reset");
  endtask

  initial begin
    test_reset();
    test_write_slot1();
    test_read_wait();
    test_timeout();
    test_race();
    test_decode_miss();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no end of test, want end before 200000");
    $fatal(1, "time limit");
  end

endmodule
